serial_block_loader: RTL
========================

SERIAL_BLOCK_LOADER -- requirements
Module: serial_block_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000000, inter-byte gap limit in Clk cycles for an open frame.
REQ-002 SHALL have port Clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port RxByte  input  8  received serial byte.
REQ-005 SHALL have port RxValid  input  1  one-cycle strobe, RxByte valid.
REQ-006 SHALL have port ReadEn  input  1  consumer acknowledge of held text block.
REQ-007 SHALL have port UserText  output  128  last complete text block.
REQ-008 SHALL have port Key  output  128  last complete key.
REQ-009 SHALL have port ReadyKey  output  1  level, valid key present.
REQ-010 SHALL have port ReadRy  output  1  level, text block held awaiting ReadEn.
REQ-011 SHALL have port ProgramSelector  output  1  0 = encrypt, 1 = decrypt, for held block.
REQ-012 SHALL have port CmdErr  output  1  one-cycle pulse, unknown command byte.
REQ-013 SHALL have port Overrun  output  1  sticky, byte dropped while block held.
REQ-014 SHALL have port Timeout  output  1  one-cycle pulse, frame aborted by gap.

Function
REQ-015 SHALL implement states IDLE, KEY_LOAD, TEXT_LOAD, TEXT_HOLD.
REQ-016 IDLE, RxValid with 0x4B ('K') SHALL clear ReadyKey, clear byte counter, enter KEY_LOAD.
REQ-017 IDLE, RxValid with 0x45 ('E') or 0x44 ('D') SHALL latch pending selector (E=0, D=1), clear counter, enter TEXT_LOAD.
REQ-018 IDLE, any other RxValid byte SHALL pulse CmdErr next cycle and remain IDLE.
REQ-019 KEY_LOAD/TEXT_LOAD SHALL shift each RxValid byte into a 128-bit shadow register, first byte ending at bits [127:120], last at [7:0].
REQ-020 4-bit byte counter SHALL increment per accepted payload byte; 16th byte (count 15) completes the frame.
REQ-021 Key completion SHALL copy shadow to Key and set ReadyKey in the cycle after the 16th byte; return to IDLE.
REQ-022 Text completion SHALL copy shadow to UserText, pending selector to ProgramSelector, set ReadRy in the cycle after the 16th byte; enter TEXT_HOLD.
REQ-023 Key and UserText SHALL change only on completion; partial frames never visible.
REQ-024 TEXT_HOLD, ReadEn high SHALL clear ReadRy next cycle and return to IDLE; UserText and ProgramSelector SHALL hold.
REQ-025 TEXT_HOLD, RxValid byte SHALL be dropped and set Overrun, including in the ReadEn cycle.
REQ-026 Overrun SHALL clear only on Rst.
REQ-027 ReadEn outside TEXT_HOLD SHALL be ignored.
REQ-028 Gap counter SHALL reset on every RxValid and count cycles in KEY_LOAD/TEXT_LOAD; reaching TIMEOUT SHALL pulse Timeout, discard the frame, enter IDLE.
REQ-029 Key timeout SHALL leave ReadyKey low and Key unchanged; text timeout SHALL leave UserText unchanged.
REQ-030 Gap counter width SHALL be clog2(TIMEOUT+1) bits and SHALL saturate, never wrap.
REQ-031 Latency from final RxValid to ReadyKey/ReadRy high SHALL be exactly 1 cycle.

Reset
REQ-032 Rst high SHALL, at the next edge, force IDLE, counters 0, UserText 0, Key 0, shadow 0, ReadyKey 0, ReadRy 0, ProgramSelector 0, CmdErr 0, Overrun 0, Timeout 0.
REQ-033 Rst mid-frame or in TEXT_HOLD SHALL abandon the operation with no completion or pulse outputs.
REQ-034 Rst SHALL take priority over RxValid and ReadEn in the same cycle.

Verification
REQ-035 Send 'K' then 0x00..0x0F -> Key = 0x000102030405060708090A0B0C0D0E0F, ReadyKey high 1 cycle after 16th byte.
REQ-036 Send 'D' then 16x 0xAA -> UserText = all 0xAA, ProgramSelector 1, ReadRy high; ReadEn pulse -> ReadRy low next cycle.
REQ-037 'E' block held, send byte 0x55 with and without ReadEn -> byte dropped, Overrun 1, UserText unchanged.
REQ-038 TIMEOUT=8, 'K' plus 5 bytes then 8 idle cycles -> Timeout pulse, IDLE, ReadyKey 0, Key unchanged.
REQ-039 Send 0x41 in IDLE -> CmdErr one-cycle pulse, state IDLE.
REQ-040 Rst after 10 text bytes -> all outputs 0; subsequent full 'E' frame completes normally.

Source files
------------

// File: rtl/serial_block_loader.sv
// serial_block_loader
//   Assembles 16-byte key and text blocks from a byte stream. Each frame starts
//   with a command byte: 'K' (0x4B) loads a key, 'E' (0x45) loads a text block
//   to encrypt, and 'D' (0x44) loads a text block to decrypt. Sixteen payload
//   bytes follow, first byte most significant. A completed text block is held
//   until the consumer acknowledges it with ReadEn. An open frame is abandoned
//   if the gap between bytes reaches TIMEOUT cycles.
//
// Parameters
//   TIMEOUT          inter-byte gap limit in Clk cycles for an open frame (>= 1)
// Ports
//   Clk              system clock, rising edge
//   Rst              synchronous active-high reset
//   RxByte/RxValid   received byte and its one-cycle strobe
//   ReadEn           consumer acknowledge of the held text block
//   UserText         last complete text block
//   Key              last complete key
//   ReadyKey         level, a valid key is present
//   ReadRy           level, a text block is held awaiting ReadEn
//   ProgramSelector  0 = encrypt, 1 = decrypt, for the held block
//   CmdErr           one-cycle pulse, unknown command byte in IDLE
//   Overrun          sticky, a byte arrived while a block was held
//   Timeout          one-cycle pulse, frame aborted by an inter-byte gap
module serial_block_loader #(
  parameter int TIMEOUT = 1000000
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [7:0]   RxByte,
  input  logic         RxValid,
  input  logic         ReadEn,
  output logic [127:0] UserText,
  output logic [127:0] Key,
  output logic         ReadyKey,
  output logic         ReadRy,
  output logic         ProgramSelector,
  output logic         CmdErr,
  output logic         Overrun,
  output logic         Timeout
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);
  // The frame is aborted on the idle cycle that would bring the gap count to
  // TIMEOUT, so the counter never needs to go past TIMEOUT-1 and cannot wrap.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_ENC = 8'h45;
  localparam logic [7:0] CMD_DEC = 8'h44;

  typedef enum logic [1:0] {
    IDLE,
    KEY_LOAD,
    TEXT_LOAD,
    TEXT_HOLD
  } stateT;

  stateT            state, stateNext;
  logic [127:0]     shadow, shadowNext;
  logic [3:0]       byteCnt, byteCntNext;
  logic [GAP_W-1:0] gapCnt, gapCntNext;
  logic             pendSel, pendSelNext;
  logic [127:0]     userTextNext, keyNext;
  logic             readyKeyNext, readRyNext, progSelNext;
  logic             cmdErrNext, overrunNext, timeoutNext;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= IDLE;
      shadow          <= '0;
      byteCnt         <= '0;
      gapCnt          <= '0;
      pendSel         <= 1'b0;
      UserText        <= '0;
      Key             <= '0;
      ReadyKey        <= 1'b0;
      ReadRy          <= 1'b0;
      ProgramSelector <= 1'b0;
      CmdErr          <= 1'b0;
      Overrun         <= 1'b0;
      Timeout         <= 1'b0;
    end else begin
      state           <= stateNext;
      shadow          <= shadowNext;
      byteCnt         <= byteCntNext;
      gapCnt          <= gapCntNext;
      pendSel         <= pendSelNext;
      UserText        <= userTextNext;
      Key             <= keyNext;
      ReadyKey        <= readyKeyNext;
      ReadRy          <= readRyNext;
      ProgramSelector <= progSelNext;
      CmdErr          <= cmdErrNext;
      Overrun         <= overrunNext;
      Timeout         <= timeoutNext;
    end
  end

  always_comb begin
    stateNext    = state;
    shadowNext   = shadow;
    byteCntNext  = byteCnt;
    gapCntNext   = gapCnt;
    pendSelNext  = pendSel;
    userTextNext = UserText;
    keyNext      = Key;
    readyKeyNext = ReadyKey;
    readRyNext   = ReadRy;
    progSelNext  = ProgramSelector;
    cmdErrNext   = 1'b0;
    overrunNext  = Overrun;
    timeoutNext  = 1'b0;

    case (state)
      IDLE: begin
        if (RxValid) begin
          case (RxByte)
            CMD_KEY: begin
              // The old key is invalid from the moment a reload starts.
              readyKeyNext = 1'b0;
              byteCntNext  = '0;
              gapCntNext   = '0;
              stateNext    = KEY_LOAD;
            end
            CMD_ENC, CMD_DEC: begin
              pendSelNext = (RxByte == CMD_DEC);
              byteCntNext = '0;
              gapCntNext  = '0;
              stateNext   = TEXT_LOAD;
            end
            default: cmdErrNext = 1'b1;
          endcase
        end
      end

      KEY_LOAD, TEXT_LOAD: begin
        if (RxValid) begin
          shadowNext  = {shadow[119:0], RxByte};
          byteCntNext = byteCnt + 4'd1;
          gapCntNext  = '0;
          if (byteCnt == 4'd15) begin
            // Completed blocks are published straight from the shifted value
            // so the outputs rise exactly one cycle after the last byte.
            if (state == KEY_LOAD) begin
              keyNext      = shadowNext;
              readyKeyNext = 1'b1;
              stateNext    = IDLE;
            end else begin
              userTextNext = shadowNext;
              progSelNext  = pendSel;
              readRyNext   = 1'b1;
              stateNext    = TEXT_HOLD;
            end
          end
        end else if (gapCnt >= GAP_LAST) begin
          timeoutNext = 1'b1;
          gapCntNext  = '0;
          stateNext   = IDLE;
        end else begin
          gapCntNext = gapCnt + 1'b1;
        end
      end

      TEXT_HOLD: begin
        // Bytes cannot be queued behind a held block; they are dropped.
        if (RxValid) begin
          overrunNext = 1'b1;
        end
        if (ReadEn) begin
          readRyNext = 1'b0;
          stateNext  = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule
